// File: rtl/reconfigurable_clock_generator.sv
// ============================================================================
// Module   : reconfigurable_clock_generator
// Function : Programmable divider producing CLK_OUT with period 8*P input
//            cycles and one of four duty cycles, reconfigured only at wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reconfigurable_clock_generator (
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic [3:0] PERIOD,
    input  logic [1:0] DUTY,
    output logic       CLK_OUT
);

    localparam logic [1:0] c_DUTY_25  = 2'd0;
    localparam logic [1:0] c_DUTY_50  = 2'd1;
    localparam logic [1:0] c_DUTY_75  = 2'd2;
    localparam logic [1:0] c_DUTY_12P = 2'd3;

    logic [3:0] r_sp;
    logic [1:0] r_sd;
    logic [6:0] r_cnt;
    logic       r_clk_out;

    logic [6:0] w_sp_ext;
    logic [6:0] w_n_last;
    logic [6:0] w_high;
    logic       w_enabled;
    logic       w_wrap;

    assign w_sp_ext  = {3'b000, r_sp};
    assign w_n_last  = {r_sp, 3'b000} - 7'd1;
    assign w_enabled = (r_sp != 4'd0);
    assign w_wrap    = (r_cnt == w_n_last);

    // High-phase length H = SP*M derived from the shadow registers only
    always_comb begin
        w_high = 7'd0;
        case (r_sd)
            c_DUTY_25:  w_high = w_sp_ext << 1;
            c_DUTY_50:  w_high = w_sp_ext << 2;
            c_DUTY_75:  w_high = (w_sp_ext << 2) + (w_sp_ext << 1);
            c_DUTY_12P: w_high = w_sp_ext;
            default:    w_high = 7'd0;
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_sp      <= 4'd0;
            r_sd      <= 2'd0;
            r_cnt     <= 7'd0;
            r_clk_out <= 1'b0;
        end else if (!w_enabled) begin
            r_clk_out <= 1'b0;
            r_cnt     <= 7'd0;
            r_sp      <= PERIOD;
            r_sd      <= DUTY;
        end else begin
            r_clk_out <= (r_cnt < w_high);
            // Settings are captured only at the wrap so no period is cut short
            if (w_wrap) begin
                r_cnt <= 7'd0;
                r_sp  <= PERIOD;
                r_sd  <= DUTY;
            end else begin
                r_cnt <= r_cnt + 7'd1;
            end
        end
    end

    assign CLK_OUT = r_clk_out;

endmodule

`default_nettype wire

// File: tb/tb_reconfigurable_clock_generator.sv
// ============================================================================
// Module   : tb_reconfigurable_clock_generator
// Function : Directed self-checking bench for reconfigurable_clock_generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reconfigurable_clock_generator;

    logic       clk_in;
    logic       rst;
    logic [3:0] period;
    logic [1:0] duty;
    logic       clk_out;

    int vectors    = 0;
    int miscompares = 0;

    reconfigurable_clock_generator dut (
        .CLK_IN  (clk_in),
        .RST     (rst),
        .PERIOD  (period),
        .DUTY    (duty),
        .CLK_OUT (clk_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Called on the first high sample of a period; returns its high and low
    // lengths in CLK_IN cycles and leaves us on the next period's first high.
    task automatic measure(output int hi, output int lo);
        hi = 1;
        lo = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (clk_out === 1'b1) hi++;
            else break;
        end
        lo = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (clk_out === 1'b0) lo++;
            else break;
        end
    endtask

    task automatic check_period(input string name, input int exp_hi, input int exp_lo);
        int hi, lo;
        measure(hi, lo);
        vectors++;
        if (hi !== exp_hi) begin
            miscompares++;
            $display("FAIL %s high: got %0d cycles, expected %0d", name, hi, exp_hi);
        end
        vectors++;
        if (lo !== exp_lo) begin
            miscompares++;
            $display("FAIL %s low: got %0d cycles, expected %0d", name, lo, exp_lo);
        end
    endtask

    // Inputs applied at a negedge: SP loads at the next edge, CLK_OUT rises one edge later
    task automatic check_startup(input string name);
        @(negedge clk_in);
        vectors++;
        if (clk_out !== 1'b0) begin
            miscompares++;
            $display("FAIL %s load-edge: got %b, expected 0", name, clk_out);
        end
        @(negedge clk_in);
        vectors++;
        if (clk_out !== 1'b1) begin
            miscompares++;
            $display("FAIL %s first-high: got %b, expected 1", name, clk_out);
        end
    endtask

    task automatic test_reset;
        int bad;
        bad = 0;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            period = 4'(i + 1);
            duty   = 2'(i);
            @(negedge clk_in);
            if (clk_out !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL reset_hold: %0d high samples, expected 0", bad);
        end
        period = 4'd0;
        duty   = 2'd0;
        rst    = 1'b0;
        bad    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (clk_out !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL disabled_after_reset: %0d high samples, expected 0", bad);
        end
    endtask

    task automatic test_basic;
        period = 4'd2;
        duty   = 2'd0;
        check_startup("p2d0_startup");
        for (int i = 0; i < 3; i++) check_period("p2d0", 4, 12);
    endtask

    task automatic test_duty_changes;
        duty = 2'd1;
        check_period("d1_pending", 4, 12);
        check_period("p2d1", 8, 8);
        duty = 2'd2;
        check_period("d2_pending", 8, 8);
        check_period("p2d2", 12, 4);
        duty = 2'd3;
        check_period("d3_pending", 12, 4);
        check_period("p2d3", 2, 14);
    endtask

    task automatic test_period_change;
        duty = 2'd1;
        check_period("d1_restore_pending", 2, 14);
        @(negedge clk_in);
        period = 4'd5;
        // Already one high sample into this period; it must still total 8/8
        begin
            int hi, lo;
            measure(hi, lo);
            vectors++;
            if (hi + 1 !== 8 || lo !== 8) begin
                miscompares++;
                $display("FAIL p5_pending: got high %0d low %0d, expected 8/8", hi + 1, lo);
            end
        end
        check_period("p5d1", 20, 20);
    endtask

    task automatic test_extremes;
        period = 4'd1;
        duty   = 2'd3;
        check_period("p1d3_pending", 20, 20);
        check_period("p1d3", 1, 7);
        check_period("p1d3_again", 1, 7);
        period = 4'd15;
        duty   = 2'd2;
        check_period("p15d2_pending", 1, 7);
        check_period("p15d2", 90, 30);
    endtask

    task automatic test_disable;
        int hi;
        period = 4'd0;
        hi = 1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk_in);
            if (clk_out === 1'b1) hi++;
        end
        vectors++;
        if (hi !== 90) begin
            miscompares++;
            $display("FAIL disable_last_period: got %0d high cycles, expected 90", hi);
        end
        period = 4'd2;
        duty   = 2'd0;
        check_startup("restart");
        check_period("restart_p2d0", 4, 12);
    endtask

    task automatic test_reset_mid_high;
        @(negedge clk_in);
        vectors++;
        if (clk_out !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_high: got %b, expected 1", clk_out);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (clk_out !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b, expected 0", clk_out);
        end
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        check_startup("post_reset");
        check_period("post_reset_p2d0", 4, 12);
    endtask

    initial begin
        rst    = 1'b1;
        period = 4'd0;
        duty   = 2'd0;
        @(negedge clk_in);
        test_reset;
        test_basic;
        test_duty_changes;
        test_period_change;
        test_extremes;
        test_disable;
        test_reset_mid_high;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
